// File: rtl/twiddle_table_builder.sv
// Walks a full-circle angle table, drives the CORDIC core per entry and writes unfolded {cos, sin} into the twiddle RAM.
// Optional WAIT watchdog with sticky Error is enabled by defining TWIDDLE_TIMEOUT_EN.
module twiddle_table_builder #(
  parameter int bw_theta = 9,
  parameter int bw_out   = 16,
  parameter int bw_addr  = 6,
  parameter int quarter  = 90,
  parameter int step     = 6,
  parameter int timeout  = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Build,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  CordicStart,
  output logic [bw_theta-1:0]   CordicTheta,
  input  logic [bw_out-1:0]     CordicCos,
  input  logic [bw_out-1:0]     CordicSin,
  input  logic                  CordicEnd,
  output logic                  WrEn,
  output logic [bw_addr-1:0]    WrAddr,
  output logic [2*bw_out-1:0]   WrData
);

  typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, DONE} builderState;

  localparam logic [bw_theta:0] quarterR = (bw_theta + 1)'(quarter);
  localparam logic [bw_theta:0] stepR    = (bw_theta + 1)'(step);

  builderState          state;
  logic [bw_addr-1:0]   k;
  logic [bw_theta:0]    r;
  logic [1:0]           q;

  logic [bw_theta:0]    rSum;
  logic [bw_theta:0]    rNext;
  logic                 rWrap;
  logic [bw_out-1:0]    negCos;
  logic [bw_out-1:0]    negSin;
  logic [bw_out-1:0]    unfoldCos;
  logic [bw_out-1:0]    unfoldSin;

  // The accumulator carries one spare bit so r + step never overflows before the wrap test.
  assign rSum  = r + stepR;
  assign rWrap = (rSum >= quarterR);
  assign rNext = rWrap ? (rSum - quarterR) : rSum;

  assign negCos = -CordicCos;
  assign negSin = -CordicSin;

  always_comb begin
    unfoldCos = CordicCos;
    unfoldSin = CordicSin;
    case (q)
      2'd1: begin unfoldCos = negSin;    unfoldSin = CordicCos; end
      2'd2: begin unfoldCos = negCos;    unfoldSin = negSin;    end
      2'd3: begin unfoldCos = CordicSin; unfoldSin = negCos;    end
      default: ;
    endcase
  end

`ifdef TWIDDLE_TIMEOUT_EN
  localparam int tw = ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
  localparam logic [tw-1:0] waitLast = tw'(timeout - 1);
  logic [tw-1:0] waitCount;
`else
  assign Error = 1'b0;
`endif

  // Single FSM; strobes default low each cycle so every pulse lasts exactly one clock.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      k           <= '0;
      r           <= '0;
      q           <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      CordicStart <= 1'b0;
      CordicTheta <= '0;
      WrEn        <= 1'b0;
      WrAddr      <= '0;
      WrData      <= '0;
`ifdef TWIDDLE_TIMEOUT_EN
      Error       <= 1'b0;
      waitCount   <= '0;
`endif
    end else begin
      Done        <= 1'b0;
      CordicStart <= 1'b0;
      WrEn        <= 1'b0;
      if (Abort) begin
        state <= IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Build) begin
              k           <= '0;
              r           <= '0;
              q           <= '0;
              Busy        <= 1'b1;
              CordicStart <= 1'b1;
              CordicTheta <= '0;
              state       <= START;
`ifdef TWIDDLE_TIMEOUT_EN
              Error       <= 1'b0;
`endif
            end
          end
          START: begin
            state <= WAIT;
`ifdef TWIDDLE_TIMEOUT_EN
            waitCount <= '0;
`endif
          end
          WAIT: begin
            if (CordicEnd) begin
              WrEn   <= 1'b1;
              WrAddr <= k;
              WrData <= {unfoldCos, unfoldSin};
              state  <= WRITE;
            end
`ifdef TWIDDLE_TIMEOUT_EN
            else if (waitCount == waitLast) begin
              Error <= 1'b1;
              Busy  <= 1'b0;
              state <= IDLE;
            end else begin
              waitCount <= waitCount + tw'(1);
            end
`endif
          end
          WRITE: begin
            k <= k + bw_addr'(1);
            r <= rNext;
            q <= q + {1'b0, rWrap};
            if (&k) begin
              Done  <= 1'b1;
              Busy  <= 1'b0;
              state <= DONE;
            end else begin
              CordicStart <= 1'b1;
              CordicTheta <= rNext[bw_theta-1:0];
              state       <= START;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_twiddle_table_builder.sv
// Bench for twiddle_table_builder: an 8-entry step-45 instance (CORDIC latency 20) and a default 64-entry instance (latency 2).
// The WAIT watchdog scenario is included when TWIDDLE_TIMEOUT_EN is defined.
module tb_twiddle_table_builder;

  localparam int latA = 20;
  localparam int latB = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        buildA, abortA, busyA, doneA, errorA, startA, endA, wrEnA;
  logic [8:0]  thetaA;
  logic [15:0] cosA, sinA;
  logic [2:0]  wrAddrA;
  logic [31:0] wrDataA;

  logic        buildB, abortB, busyB, doneB, errorB, startB, endB, wrEnB;
  logic [8:0]  thetaB;
  logic [15:0] cosB, sinB;
  logic [5:0]  wrAddrB;
  logic [31:0] wrDataB;

  twiddle_table_builder #(.bw_theta(9), .bw_out(16), .bw_addr(3), .quarter(90), .step(45), .timeout(255)) dutA (
    .Clock(clock), .Reset(reset), .Build(buildA), .Abort(abortA),
    .Busy(busyA), .Done(doneA), .Error(errorA),
    .CordicStart(startA), .CordicTheta(thetaA),
    .CordicCos(cosA), .CordicSin(sinA), .CordicEnd(endA),
    .WrEn(wrEnA), .WrAddr(wrAddrA), .WrData(wrDataA)
  );

  twiddle_table_builder dutB (
    .Clock(clock), .Reset(reset), .Build(buildB), .Abort(abortB),
    .Busy(busyB), .Done(doneB), .Error(errorB),
    .CordicStart(startB), .CordicTheta(thetaB),
    .CordicCos(cosB), .CordicSin(sinB), .CordicEnd(endB),
    .WrEn(wrEnB), .WrAddr(wrAddrB), .WrData(wrDataB)
  );

  int nVec = 0;
  int nErr = 0;

  bit killA = 0, cordicOffA = 0, strayA = 0;
  int epochA = 0;
  int buildCycA = 0;

  int wrCountA = 0, doneCountA = 0, doneCycA = 0, startCycA = 0, errCycA = 0;
  int wrCountB = 0, doneCountB = 0;
  logic [31:0] memA [8];
  logic [31:0] memB [64];
  int thetaLogB [64];

  function automatic logic [31:0] cordicA(input int theta);
    case (theta)
      0:       return {16'h7FF0, 16'h0010};
      45:      return {16'h5A82, 16'h5A82};
      default: return 32'h1111_2222;
    endcase
  endfunction

  function automatic logic [31:0] cordicB(input int theta);
    logic [15:0] c;
    c = 16'h1000 + 16'(theta);
    return {c, 16'(theta)};
  endfunction

  // Full-circle angle of entry idx, reduced to quadrant and first-quadrant remainder.
  function automatic int thetaOf(input int idx, input int stp, input int qtr);
    return (idx * stp) % qtr;
  endfunction

  function automatic logic [31:0] entryOf(input int idx, input int stp, input int qtr, input logic [31:0] cs);
    logic [15:0] c, s, nc, ns;
    c = cs[31:16];
    s = cs[15:0];
    nc = -c;
    ns = -s;
    case (((idx * stp) / qtr) % 4)
      0:       return {c, s};
      1:       return {ns, c};
      2:       return {nc, ns};
      default: return {s, nc};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVec++;
    if (actual !== expected) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit bA, input bit aA, input bit bB);
    buildA = bA;
    abortA = aA;
    buildB = bB;
    if (bA) buildCycA = cyc;
    @(posedge clock);
    #1;
    buildA = 1'b0;
    abortA = 1'b0;
    buildB = 1'b0;
  endtask

  task automatic waitIdle(input bit onB, input string name);
    int n;
    n = 0;
    while ((onB ? busyB : busyA) && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(name, {63'd0, (onB ? busyB : busyA)}, 64'd0);
    waitCycles(3);
  endtask

  task automatic waitWritesA(input int target, input string name);
    int n;
    n = 0;
    while (wrCountA < target && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(name, {63'd0, wrCountA >= target}, 64'd1);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, ".Busy"},        {63'd0, busyA},  64'd0);
    checkOutput({tag, ".Done"},        {63'd0, doneA},  64'd0);
    checkOutput({tag, ".Error"},       {63'd0, errorA}, 64'd0);
    checkOutput({tag, ".CordicStart"}, {63'd0, startA}, 64'd0);
    checkOutput({tag, ".CordicTheta"}, {55'd0, thetaA}, 64'd0);
    checkOutput({tag, ".WrEn"},        {63'd0, wrEnA},  64'd0);
    checkOutput({tag, ".WrAddr"},      {61'd0, wrAddrA}, 64'd0);
    checkOutput({tag, ".WrData"},      {32'd0, wrDataA}, 64'd0);
  endtask

  // CORDIC stand-in for dutA: answers latA cycles after each start, holding End for one sampling edge.
  initial begin
    int cnt;
    logic [8:0] held;
    cnt = 0;
    held = '0;
    endA = 1'b0;
    cosA = '0;
    sinA = '0;
    forever begin
      @(negedge clock);
      endA = 1'b0;
      if (!reset || killA) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            endA = 1'b1;
            {cosA, sinA} = cordicA(int'(held));
          end
        end
        if (startA && !cordicOffA) begin
          cnt = latA;
          held = thetaA;
        end
      end
      if (strayA) endA = 1'b1;
    end
  end

  initial begin
    int cnt;
    logic [8:0] held;
    cnt = 0;
    held = '0;
    endB = 1'b0;
    cosB = '0;
    sinB = '0;
    forever begin
      @(negedge clock);
      endB = 1'b0;
      if (!reset) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            endB = 1'b1;
            {cosB, sinB} = cordicB(int'(held));
          end
        end
        if (startB) begin
          cnt = latB;
          held = thetaB;
        end
      end
    end
  end

  // Compare process: every start and write is checked against the angle-table model.
  initial begin
    int seenEpoch, startIdxA, wrIdxA, startIdxB, wrIdxB;
    logic prevErr;
    seenEpoch = 0;
    startIdxA = 0;
    wrIdxA = 0;
    startIdxB = 0;
    wrIdxB = 0;
    prevErr = 1'b0;
    forever begin
      @(negedge clock);
      if (epochA != seenEpoch) begin
        seenEpoch = epochA;
        startIdxA = 0;
        wrIdxA = 0;
      end
      if (reset) begin
        if (startA) begin
          checkOutput("thetaA", {55'd0, thetaA}, 64'(thetaOf(startIdxA, 45, 90)));
          startIdxA++;
          startCycA = cyc;
        end
        if (wrEnA) begin
          checkOutput("wrAddrA", {61'd0, wrAddrA}, 64'(wrIdxA % 8));
          checkOutput("wrDataA", {32'd0, wrDataA},
                      {32'd0, entryOf(wrIdxA, 45, 90, cordicA(thetaOf(wrIdxA, 45, 90)))});
          memA[wrAddrA] = wrDataA;
          wrIdxA++;
          wrCountA++;
        end
        if (doneA) begin
          doneCountA++;
          doneCycA = cyc;
        end
        if (errorA && !prevErr) errCycA = cyc;
        prevErr = errorA;
        if (startB) begin
          checkOutput("thetaB", {55'd0, thetaB}, 64'(thetaOf(startIdxB, 6, 90)));
          thetaLogB[startIdxB % 64] = int'(thetaB);
          startIdxB++;
        end
        if (wrEnB) begin
          checkOutput("wrAddrB", {58'd0, wrAddrB}, 64'(wrIdxB % 64));
          checkOutput("wrDataB", {32'd0, wrDataB},
                      {32'd0, entryOf(wrIdxB, 6, 90, cordicB(thetaOf(wrIdxB, 6, 90)))});
          memB[wrAddrB] = wrDataB;
          wrIdxB++;
          wrCountB++;
        end
        if (doneB) doneCountB++;
      end else begin
        prevErr = 1'b0;
      end
    end
  end

  initial begin
    int baseWr, baseDone;
    buildA = 1'b0;
    abortA = 1'b0;
    buildB = 1'b0;
    abortB = 1'b0;

    #3 reset = 1'b0;
    #1;
    checkResetA("powerOn");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    waitCycles(2);

    // A CordicEnd while idle must not produce a write.
    baseWr = wrCountA;
    strayA = 1'b1;
    waitCycles(1);
    strayA = 1'b0;
    waitCycles(3);
    checkOutput("strayEnd", 64'(wrCountA - baseWr), 64'd0);

    // Full build on both instances.
    epochA++;
    baseWr = wrCountA;
    baseDone = doneCountA;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("busyRise", {63'd0, busyA}, 64'd1);
    waitIdle(1'b0, "fullBuildA.finish");
    checkOutput("fullBuildA.doneCycle", 64'(doneCycA - buildCycA), 64'd177);
    checkOutput("fullBuildA.writes", 64'(wrCountA - baseWr), 64'd8);
    checkOutput("fullBuildA.dones", 64'(doneCountA - baseDone), 64'd1);
    checkOutput("entry0", {32'd0, memA[0]}, 64'h7FF0_0010);
    checkOutput("entry1", {32'd0, memA[1]}, 64'h5A82_5A82);
    checkOutput("entry2", {32'd0, memA[2]}, 64'hFFF0_7FF0);
    checkOutput("entry5", {32'd0, memA[5]}, 64'hA57E_A57E);
    checkOutput("entry7", {32'd0, memA[7]}, 64'h5A82_A57E);
    waitIdle(1'b1, "fullBuildB.finish");
    checkOutput("fullBuildB.writes", 64'(wrCountB), 64'd64);
    checkOutput("fullBuildB.dones", 64'(doneCountB), 64'd1);
    checkOutput("thetaB14", 64'(thetaLogB[14]), 64'd84);
    checkOutput("thetaB15", 64'(thetaLogB[15]), 64'd0);
    checkOutput("entryB15", {32'd0, memB[15]}, 64'h0000_1000);
    checkOutput("entryB16", {32'd0, memB[16]}, 64'hFFFA_1006);

    // Build while busy is ignored.
    epochA++;
    baseWr = wrCountA;
    baseDone = doneCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitWritesA(baseWr + 4, "busyBuild.reachEntry4");
    waitCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle(1'b0, "busyBuild.finish");
    checkOutput("busyBuild.writes", 64'(wrCountA - baseWr), 64'd8);
    checkOutput("busyBuild.dones", 64'(doneCountA - baseDone), 64'd1);

    // Abort in WAIT of entry 2, then a normal build.
    epochA++;
    baseWr = wrCountA;
    baseDone = doneCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitWritesA(baseWr + 2, "abort.reachEntry2");
    waitCycles(3);
    killA = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort.busy", {63'd0, busyA}, 64'd0);
    waitCycles(30);
    killA = 1'b0;
    checkOutput("abort.writes", 64'(wrCountA - baseWr), 64'd2);
    checkOutput("abort.dones", 64'(doneCountA - baseDone), 64'd0);
    epochA++;
    baseWr = wrCountA;
    baseDone = doneCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle(1'b0, "afterAbort.finish");
    checkOutput("afterAbort.writes", 64'(wrCountA - baseWr), 64'd8);
    checkOutput("afterAbort.dones", 64'(doneCountA - baseDone), 64'd1);

    // Abort and Build together while idle: nothing starts.
    baseWr = wrCountA;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("abortBuild.busy", {63'd0, busyA}, 64'd0);
    waitCycles(30);
    checkOutput("abortBuild.writes", 64'(wrCountA - baseWr), 64'd0);

    // Reset mid-WAIT of entry 3, then restart from entry 0.
    epochA++;
    baseWr = wrCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitWritesA(baseWr + 3, "reset.reachEntry3");
    waitCycles(4);
    #3 reset = 1'b0;
    #1;
    checkResetA("midWait");
    waitCycles(3);
    reset = 1'b1;
    waitCycles(2);
    epochA++;
    baseWr = wrCountA;
    baseDone = doneCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle(1'b0, "afterReset.finish");
    checkOutput("afterReset.writes", 64'(wrCountA - baseWr), 64'd8);
    checkOutput("afterReset.dones", 64'(doneCountA - baseDone), 64'd1);

`ifdef TWIDDLE_TIMEOUT_EN
    // CORDIC never answers: watchdog flags Error after 255 WAIT cycles.
    cordicOffA = 1'b1;
    epochA++;
    baseWr = wrCountA;
    baseDone = doneCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle(1'b0, "timeout.busyDrop");
    checkOutput("timeout.error", {63'd0, errorA}, 64'd1);
    checkOutput("timeout.cycles", 64'(errCycA - startCycA), 64'd256);
    checkOutput("timeout.writes", 64'(wrCountA - baseWr), 64'd0);
    checkOutput("timeout.dones", 64'(doneCountA - baseDone), 64'd0);
    cordicOffA = 1'b0;
    epochA++;
    baseWr = wrCountA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("timeout.errorCleared", {63'd0, errorA}, 64'd0);
    waitIdle(1'b0, "timeout.rebuild");
    checkOutput("timeout.rebuildWrites", 64'(wrCountA - baseWr), 64'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/twiddle_table_builder.md
# twiddle_table_builder

Sequencer placed directly upstream of the CORDIC sin/cos core. On a build request it walks a full-circle angle table, folds each angle into the first quadrant, and issues one CORDIC request per entry. It unfolds each CORDIC result into the correct quadrant and writes `{cos, sin}` into the FFT twiddle RAM. Build runs once after power-up or after a configuration change; the FFT engine waits on `Done` before it uses the table.

## Interface

- `bw_theta`, default 9: CORDIC angle width, first-quadrant units.
- `bw_out`, default 16: CORDIC result width, two's complement.
- `bw_addr`, default 6: table address width; depth = 2**bw_addr.
- `quarter`, default 90: angle units per quadrant; must be < 2**bw_theta.
- `step`, default 6: angle increment per entry; must be ≤ quarter.
- `timeout`, default 255: maximum cycles allowed in WAIT (used only with TWIDDLE_TIMEOUT_EN).
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: reset, asynchronous, active-low.
- `Build` in 1: one-cycle build request.
- `Abort` in 1: synchronous abort.
- `Busy` out 1: build in progress.
- `Done` out 1: one-cycle pulse at completion.
- `Error` out 1: sticky timeout flag (TWIDDLE_TIMEOUT_EN only, else tied 0).
- `CordicStart` out 1: one-cycle request to CORDIC.
- `CordicTheta` out bw_theta: folded angle; held stable from START until the next START.
- `CordicCos`, `CordicSin` in bw_out each: CORDIC results, non-negative.
- `CordicEnd` in 1: CORDIC completion pulse.
- `WrEn` out 1: twiddle RAM write strobe.
- `WrAddr` out bw_addr: table index k.
- `WrData` out 2*bw_out: {cos, sin} with cos in the MSBs.

## Operation

- **States:** IDLE, START, WAIT, WRITE, DONE.
- **IDLE:** `Build`=1 loads k=0, r=0, q=0, clears `Error`, and moves to START.
- **START:** drive `CordicStart`=1 and `CordicTheta`=r, then go to WAIT.
- **WAIT:**
  - `CordicEnd` is sampled only in this state.
  - On `CordicEnd`, register the unfolded result and go to WRITE.
- **Unfolding by quadrant q** (negation is two's complement at bw_out; inputs are non-negative, so it cannot overflow):
  - q0: (C, S)
  - q1: (−S, C)
  - q2: (−C, −S)
  - q3: (S, −C)
- **WRITE:**
  - Assert `WrEn` with `WrAddr`=k.
  - Advance k. Set r += step; if r ≥ quarter, then r −= quarter and q = (q+1) mod 4.
  - If k was depth−1, go to DONE; otherwise go to START.
- **DONE:** `Done`=1 for one cycle, then go to IDLE.
- **Width rules:** the r accumulator is bw_theta+1 bits so r+step cannot overflow; q is 2 bits and wraps.
- **Build while Busy:** ignored.
- **Abort** (any non-IDLE state): go to IDLE next edge. No `Done`. `WrEn` is forced 0 in that cycle. Entries already written are left untouched.
- **Abort and Build in the same cycle while in IDLE:** Abort wins; the build does not start.
- **Reset low at any time:** all outputs go to 0, FSM to IDLE, counters to 0.
- **Reset values:** `Busy`, `Done`, `Error`, `CordicStart`, `CordicTheta`, `WrEn`, `WrAddr`, `WrData` are all 0.

## Timing

- All outputs are registered.
- `Busy` rises the edge after `Build` is sampled, and falls on the same edge that `Done` rises.
- `CordicStart` asserts the cycle after `Build` (or after the previous WRITE).
- Per entry: 1 START cycle + L (CORDIC Start-to-End latency) + 1 WRITE cycle.
- `WrEn` is high for the cycle after `CordicEnd`.
- `Done` follows the last `WrEn` by 1 cycle.
- Total from `Build` to `Done`: 1 + depth·(L+2) cycles.
- A `CordicEnd` arriving outside WAIT is ignored.

## Configuration

- **With `TWIDDLE_TIMEOUT_EN` defined:**
  - An 8-bit-or-wider counter runs in WAIT.
  - If it reaches `timeout` with no `CordicEnd`: set `Error`=1 (sticky until the next accepted `Build` or reset), go to IDLE, no `Done`.
- **Without `TWIDDLE_TIMEOUT_EN`:** WAIT waits indefinitely, no counter logic is present, and `Error` is constant 0.

## Test plan

- **Reset check:** drive `Reset` low mid-WAIT of entry 3 → all outputs 0 immediately. After release, `Build` restarts from k=0.
- **Full build:** bw_addr=3, quarter=90, step=45, and a CORDIC model with L=20 returning (0x7FF0, 0x0010) for θ=0 and (0x5A82, 0x5A82) for θ=45. Pulse `Build`, then check:
  - `WrData`[0]=0x7FF00010
  - `WrData`[1]=0x5A825A82
  - `WrData`[2]=0xFFF07FF0
  - `WrData`[5]=0xA57EA57E
  - `WrData`[7]=0x5A82A57E
  - `Done` at cycle 1+8·22=177.
- **Theta sequence:** step=6, quarter=90, depth=64 → `CordicTheta` sequence 0,6,…,84,0,6,… and `WrAddr`=15 is written with q=1, r=0.
- **Build while busy:** pulse `Build` during entry 4 → no restart, exactly 8 `WrEn` pulses, single `Done`.
- **Abort:** assert `Abort` in WAIT of entry 2 → IDLE next cycle, 2 writes total, no `Done`. A following `Build` completes normally.
- **Timeout (TWIDDLE_TIMEOUT_EN, timeout=255):** CORDIC model never asserts End → `Error`=1 after 255 WAIT cycles, `Busy` drops, no `Done`. A subsequent `Build` clears `Error`.
